axis_blk_collector: RTL and testbench
=====================================

AXIS_BLK_COLLECTOR -- requirements
Module: axis_blk_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI-stream word width in bits, a multiple of 8.
REQ-002 SHALL have parameter IN_WORDS, default 20: number of words per inbound frame.
REQ-003 SHALL have parameter OUT_WORDS, default 8: number of words per result frame.
REQ-004 SHALL have parameter SWAP_BYTES, default 0: when 1, reverse the byte order of each inbound word before storing it.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port s_axis_tdata, input, DATA_WIDTH bits: inbound word.
REQ-008 SHALL have port s_axis_tvalid, input, 1 bit: inbound word valid.
REQ-009 SHALL have port s_axis_tready, output, 1 bit: block accepts an inbound word.
REQ-010 SHALL have port s_axis_tlast, input, 1 bit: inbound frame end marker.
REQ-011 SHALL have port m_axis_tdata, output, DATA_WIDTH bits: result word.
REQ-012 SHALL have port m_axis_tvalid, output, 1 bit: result word valid.
REQ-013 SHALL have port m_axis_tready, input, 1 bit: downstream accepts the result word.
REQ-014 SHALL have port m_axis_tlast, output, 1 bit: marks the last result word.
REQ-015 SHALL have port core_blk, output, IN_WORDS*DATA_WIDTH bits: assembled block presented to the core.
REQ-016 SHALL have port core_start, output, 1 bit: one-cycle start pulse to the core.
REQ-017 SHALL have port core_result, input, OUT_WORDS*DATA_WIDTH bits: core result.
REQ-018 SHALL have port core_done, input, 1 bit: core result is valid.
REQ-019 SHALL have port err_frame, output, 1 bit: one-cycle pulse on a short (malformed) frame.

Function
REQ-020 SHALL implement four states: COLLECT, START, WAIT, SEND.
REQ-021 SHALL complete a handshake on a channel when tvalid and tready are both high at the same rising edge.
REQ-022 SHALL drive s_axis_tready high only in COLLECT and m_axis_tvalid high only in SEND.
REQ-023 SHALL store inbound word k (0-based) at core_blk[k*DATA_WIDTH +: DATA_WIDTH], with word 0 in the LSBs, byte-swapped first if SWAP_BYTES=1.
REQ-024 SHALL use a word counter 0..IN_WORDS-1; the handshake at count IN_WORDS-1 moves COLLECT to START and clears the counter, whether or not tlast is set.
REQ-025 SHALL treat tlast on a handshake with count < IN_WORDS-1 as a short frame: discard the frame, clear the counter, pulse err_frame for 1 cycle the next cycle, and stay in COLLECT.
REQ-026 SHALL hold core_start high for exactly the single START cycle, which is the cycle after the final inbound handshake, then move to WAIT.
REQ-027 SHALL hold core_blk stable from entry to START until the next frame's first handshake.
REQ-028 SHALL, in WAIT, capture core_result into an output register on the edge where core_done=1, and enter SEND with m_axis_tvalid high the next cycle.
REQ-029 SHALL ignore core_done in any state other than WAIT.
REQ-030 SHALL emit result word j = core_result[j*DATA_WIDTH +: DATA_WIDTH] in order j=0..OUT_WORDS-1, with no byte swap.
REQ-031 SHALL hold m_axis_tdata and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-032 SHALL assert m_axis_tlast only on word OUT_WORDS-1.
REQ-033 SHALL, after the last result handshake, return to COLLECT, with s_axis_tready high the following cycle.
REQ-034 SHALL support back-to-back handshakes every cycle on both channels.

Reset
REQ-035 SHALL, while reset=1, put the block in COLLECT with counters 0, core_blk=0, output register=0, and s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, core_start=0, err_frame=0.
REQ-036 SHALL drive s_axis_tready=1 in the first cycle after reset deasserts.
REQ-037 SHALL abort any in-progress frame or result on reset mid-operation, with no partial output afterwards.

Verification (DATA_WIDTH=32, IN_WORDS=20, OUT_WORDS=8)
REQ-038 SHALL check: 20 words 0x00000000..0x00000013, tlast on the last -> one core_start pulse the cycle after the 20th handshake; core_blk[31:0]=0x00000000, core_blk[639:608]=0x00000013.
REQ-039 SHALL check: tlast on the 6th word -> err_frame pulse, no core_start; a following full 20-word frame starts the core normally.
REQ-040 SHALL check: core_done with result words 0xA0..0xA7, m_axis_tready oscillating 2 cycles low / 6 cycles high -> 8 words 0xA0..0xA7 in order, data stable during stalls, tlast only on 0xA7.
REQ-041 SHALL check: SWAP_BYTES=1, input word 0 = 0x11223344 -> core_blk[31:0]=0x44332211.
REQ-042 SHALL check: reset after 3 result handshakes -> m_axis_tvalid=0 the next cycle and s_axis_tready=1 after release; a new frame then completes normally.
REQ-043 SHALL check: core_done pulsed during COLLECT -> no m_axis_tvalid, and collection continues unaffected.

Source files
------------

// File: rtl/axis_blk_collector.sv
// ============================================================================
//  Module   : axis_blk_collector
//  Purpose  : Gathers a fixed-length AXI-stream frame into a flat block for a
//             core, then streams the core's result back out word by word.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module axis_blk_collector #(
    parameter int DATA_WIDTH = 32,
    parameter int IN_WORDS   = 20,
    parameter int OUT_WORDS  = 8,
    parameter int SWAP_BYTES = 0
) (
    input  logic                            aclk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic [IN_WORDS*DATA_WIDTH-1:0]  core_blk,
    output logic                            core_start,
    input  logic [OUT_WORDS*DATA_WIDTH-1:0] core_result,
    input  logic                            core_done,
    output logic                            err_frame
);

    localparam int c_bytes = DATA_WIDTH / 8;
    localparam int c_cnt_w = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int c_idx_w = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        START   = 2'd1,
        WAIT    = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [c_cnt_w-1:0]              r_count;
    logic [c_idx_w-1:0]              r_idx;
    logic [IN_WORDS*DATA_WIDTH-1:0]  r_blk;
    logic [OUT_WORDS*DATA_WIDTH-1:0] r_res;
    logic                            r_err;

    logic [DATA_WIDTH-1:0]           w_in_word;
    logic [DATA_WIDTH-1:0]           w_out_word;
    logic                            w_s_hs;
    logic                            w_m_hs;
    logic                            w_cnt_last;
    logic                            w_idx_last;

    generate
        if (SWAP_BYTES != 0) begin : g_swap
            for (genvar b = 0; b < c_bytes; b++) begin : g_byte
                assign w_in_word[b*8 +: 8] = s_axis_tdata[(c_bytes-1-b)*8 +: 8];
            end
        end else begin : g_noswap
            assign w_in_word = s_axis_tdata;
        end
    endgenerate

    // Ready/valid are gated by reset so the block is silent while held in reset.
    assign s_axis_tready = (r_state == COLLECT) && !reset;
    assign m_axis_tvalid = (r_state == SEND) && !reset;
    assign m_axis_tlast  = m_axis_tvalid && w_idx_last;
    assign m_axis_tdata  = w_out_word;
    assign core_start    = (r_state == START);
    assign core_blk      = r_blk;
    assign err_frame     = r_err;

    assign w_s_hs     = s_axis_tvalid && s_axis_tready;
    assign w_m_hs     = m_axis_tvalid && m_axis_tready;
    assign w_cnt_last = (r_count == c_cnt_w'(IN_WORDS - 1));
    assign w_idx_last = (r_idx == c_idx_w'(OUT_WORDS - 1));

    always_comb begin
        w_out_word = '0;
        for (int j = 0; j < OUT_WORDS; j++) begin
            if (r_idx == c_idx_w'(j)) begin
                w_out_word = r_res[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            COLLECT: if (w_s_hs && w_cnt_last)  w_next = START;
            START:                              w_next = WAIT;
            WAIT:    if (core_done)             w_next = SEND;
            SEND:    if (w_m_hs && w_idx_last)  w_next = COLLECT;
            default:                            w_next = COLLECT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= COLLECT;
            r_count <= '0;
            r_idx   <= '0;
            r_blk   <= '0;
            r_res   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= 1'b0;

            if (w_s_hs) begin
                for (int k = 0; k < IN_WORDS; k++) begin
                    if (r_count == c_cnt_w'(k)) begin
                        r_blk[k*DATA_WIDTH +: DATA_WIDTH] <= w_in_word;
                    end
                end
                // A full count always completes the frame; tlast only matters early.
                if (w_cnt_last || s_axis_tlast) begin
                    r_count <= '0;
                end else begin
                    r_count <= r_count + 1'b1;
                end
                if (!w_cnt_last && s_axis_tlast) begin
                    r_err <= 1'b1;
                end
            end

            if ((r_state == WAIT) && core_done) begin
                r_res <= core_result;
                r_idx <= '0;
            end

            if (w_m_hs) begin
                r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_blk_collector.sv
// Directed bench for axis_blk_collector: frame table plus reset/abort sequences.
`default_nettype none

module tb_axis_blk_collector;

    localparam int DW = 32;
    localparam int NI = 20;
    localparam int NO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [DW-1:0]     s_tdata;
    logic              s_tvalid;
    logic              s_tlast;
    logic              m_tready;
    logic [NO*DW-1:0]  core_result;
    logic              core_done;

    logic              s_tready, m_tvalid, m_tlast, core_start, err_frame;
    logic [DW-1:0]     m_tdata;
    logic [NI*DW-1:0]  core_blk;

    logic              sw_s_tready, sw_m_tvalid, sw_m_tlast, sw_core_start, sw_err_frame;
    logic [DW-1:0]     sw_m_tdata;
    logic [NI*DW-1:0]  sw_core_blk;

    axis_blk_collector #(.DATA_WIDTH(DW), .IN_WORDS(NI), .OUT_WORDS(NO), .SWAP_BYTES(0)) dut (
        .aclk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .core_blk(core_blk), .core_start(core_start), .core_result(core_result),
        .core_done(core_done), .err_frame(err_frame)
    );

    axis_blk_collector #(.DATA_WIDTH(DW), .IN_WORDS(NI), .OUT_WORDS(NO), .SWAP_BYTES(1)) dut_sw (
        .aclk(clk), .reset(reset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(sw_s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(sw_m_tdata), .m_axis_tvalid(sw_m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(sw_m_tlast),
        .core_blk(sw_core_blk), .core_start(sw_core_start), .core_result(core_result),
        .core_done(core_done), .err_frame(sw_err_frame)
    );

    int n_vec  = 0;
    int n_bad  = 0;
    int n_start = 0;
    int n_errp  = 0;

    always @(posedge clk) begin
        if (core_start) n_start++;
        if (err_frame)  n_errp++;
    end

    typedef struct {
        int          len;
        bit          tl;
        logic [31:0] base;
        logic [31:0] rbase;
        int          stall;
        bit          glitch;
    } vec_t;

    vec_t tbl [6];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_blk(input string nm, input logic [NI*DW-1:0] act, input logic [NI*DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [NI*DW-1:0] mk_blk(input logic [31:0] base, input bit sw);
        logic [NI*DW-1:0] b;
        logic [31:0]      w;
        b = '0;
        for (int k = 0; k < NI; k++) begin
            w = base + 32'(k);
            b[k*DW +: DW] = sw ? bswap(w) : w;
        end
        return b;
    endfunction

    task automatic send_frame(input vec_t v);
        int s0, e0, b;
        s0 = n_start;
        e0 = n_errp;
        for (int k = 0; k < v.len; k++) begin
            if (v.glitch && k == 5) begin
                core_result = {NO{32'hDEAD_BEEF}};
                core_done   = 1'b1;
                tick();
                core_done   = 1'b0;
                chk("glitch_no_tvalid", 64'(m_tvalid), 64'd0);
                chk("glitch_tready", 64'(s_tready), 64'd1);
            end
            s_tdata  = v.base + 32'(k);
            s_tlast  = v.tl && (k == v.len - 1);
            s_tvalid = 1'b1;
            b = 0;
            while (!s_tready && b < 50) begin
                tick();
                b++;
            end
            if (b >= 50) chk("s_tready_timeout", 64'd0, 64'd1);
            tick();
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
        if (v.len == NI) begin
            chk("core_start_hi", 64'(core_start), 64'd1);
            chk_blk("core_blk", core_blk, mk_blk(v.base, 1'b0));
            chk_blk("core_blk_swap", sw_core_blk, mk_blk(v.base, 1'b1));
            tick();
            chk("core_start_lo", 64'(core_start), 64'd0);
            chk("start_pulses", 64'(n_start - s0), 64'd1);
            chk("wait_no_tvalid", 64'(m_tvalid), 64'd0);
            chk("wait_no_tready", 64'(s_tready), 64'd0);
        end else begin
            chk("err_frame_hi", 64'(err_frame), 64'd1);
            tick();
            chk("err_frame_lo", 64'(err_frame), 64'd0);
            chk("err_pulses", 64'(n_errp - e0), 64'd1);
            chk("short_no_start", 64'(n_start - s0), 64'd0);
            chk("short_tready", 64'(s_tready), 64'd1);
        end
    endtask

    task automatic recv_result(input vec_t v, input int max_words);
        int j, c;
        for (int i = 0; i < NO; i++) core_result[i*DW +: DW] = v.rbase + 32'(i);
        tick();
        chk("wait_idle_tvalid", 64'(m_tvalid), 64'd0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        j = 0;
        c = 0;
        while (j < max_words && c < 200) begin
            m_tready = (v.stall == 0) ? 1'b1 : ((c % 8) >= v.stall);
            chk("m_tvalid", 64'(m_tvalid), 64'd1);
            chk("m_tdata", 64'(m_tdata), 64'(v.rbase + 32'(j)));
            chk("m_tlast", 64'(m_tlast), 64'(j == NO - 1));
            if (m_tready) j++;
            tick();
            c++;
        end
        m_tready = 1'b0;
        if (c >= 200) chk("m_recv_timeout", 64'd0, 64'd1);
        if (max_words == NO) begin
            chk("done_no_tvalid", 64'(m_tvalid), 64'd0);
            chk("done_tready", 64'(s_tready), 64'd1);
            chk_blk("core_blk_hold", core_blk, mk_blk(v.base, 1'b0));
        end
    endtask

    initial begin
        logic [NI*DW-1:0] blk;
        vec_t             rv;

        tbl[0] = '{20, 1'b1, 32'h0000_0000, 32'h0000_00A0, 2, 1'b0};
        tbl[1] = '{6,  1'b1, 32'h0000_0100, 32'h0,          0, 1'b0};
        tbl[2] = '{20, 1'b1, 32'h0000_0200, 32'h0000_00B0, 0, 1'b0};
        tbl[3] = '{20, 1'b0, 32'h1122_3344, 32'h0000_00C0, 1, 1'b1};
        tbl[4] = '{1,  1'b1, 32'h0000_0300, 32'h0,          0, 1'b0};
        tbl[5] = '{20, 1'b1, 32'hFFFF_FFF0, 32'h0000_00D0, 3, 1'b0};

        reset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b0; core_result = '0; core_done = 1'b0;
        tick(); tick(); tick();
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata), 64'd0);
        chk("rst_core_start", 64'(core_start), 64'd0);
        chk("rst_err_frame", 64'(err_frame), 64'd0);
        chk_blk("rst_core_blk", core_blk, '0);
        reset = 1'b0;
        #1;
        chk("post_rst_tready", 64'(s_tready), 64'd1);

        for (int i = 0; i < 6; i++) begin
            send_frame(tbl[i]);
            if (i == 0) begin
                blk = core_blk;
                chk("blk_word0", 64'(blk[31:0]), 64'h0);
                chk("blk_word19", 64'(blk[639:608]), 64'h13);
            end
            if (i == 3) begin
                blk = sw_core_blk;
                chk("swap_word0", 64'(blk[31:0]), 64'h4433_2211);
            end
            if (tbl[i].len == NI) recv_result(tbl[i], NO);
        end

        // Reset in the middle of result streaming, then a clean frame.
        rv = '{20, 1'b1, 32'h0000_0500, 32'h0000_00E0, 0, 1'b0};
        send_frame(rv);
        recv_result(rv, 3);
        reset = 1'b1;
        tick();
        chk("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("midrst_s_tready", 64'(s_tready), 64'd0);
        chk("midrst_m_tdata", 64'(m_tdata), 64'd0);
        chk_blk("midrst_core_blk", core_blk, '0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_release_tready", 64'(s_tready), 64'd1);
        chk("midrst_release_tvalid", 64'(m_tvalid), 64'd0);
        rv = '{20, 1'b1, 32'h0000_0600, 32'h0000_00F0, 2, 1'b0};
        send_frame(rv);
        recv_result(rv, NO);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
